// File: rtl/commit_pkg.sv
// Shared types for the commit queue: queued entry layout, retire FSM states and xRET bit positions.
package commit_pkg;

  localparam int ENTRY_XLEN   = 32;
  localparam int ENTRY_CSR_AW = 12;

  // Bit positions inside the {mret,sret,uret} vector
  localparam int XRET_M = 2;
  localparam int XRET_S = 1;
  localparam int XRET_U = 0;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0]   result;
    logic [4:0]              rd;
    logic                    we;
    logic [ENTRY_XLEN-1:0]   pc;
    logic [ENTRY_XLEN-1:0]   csr_wb;
    logic [ENTRY_CSR_AW-1:0] csr_addr;
    logic                    csr_we;
    logic [ENTRY_XLEN-1:0]   cause;
    logic                    exc;
    logic [2:0]              xret;
  } commit_entry_t;

endpackage

// File: rtl/commit_fifo.sv
// Circular entry store for the commit queue: push at tail, pop at head, clear drops every queued entry.
// Head is read combinationally so the retire stage can register it on the pop edge.
module commit_fifo
  import commit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  commit_entry_t           wr_entry,
  output commit_entry_t           head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);

  commit_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  // A clear on the same edge discards the push and the pop alike
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      rd_ptr_reg <= wr_ptr_reg;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/commit_queue.sv
// In-order retire stage: buffers stage-6 results, drives GPR/CSR write ports, raises trap/xRET/flush pulses.
// Build option: define COMMIT_PERF_CNT_EN to add the instret and trap_cnt counters.
module commit_queue
  import commit_pkg::*;
#(
  parameter int XLEN   = ENTRY_XLEN,
  parameter int DEPTH  = 4,
  parameter int CSR_AW = ENTRY_CSR_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_result,
  input  logic [4:0]             in_rd,
  input  logic                   in_we,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [XLEN-1:0]        in_csr_wb,
  input  logic [CSR_AW-1:0]      in_csr_addr,
  input  logic                   in_csr_we,
  input  logic [XLEN-1:0]        in_cause,
  input  logic                   in_exc,
  input  logic [2:0]             in_xret,
  input  logic                   commit_stall,
  input  logic                   redirect_ack,
  output logic                   wb_we,
  output logic [4:0]             wb_rd,
  output logic [XLEN-1:0]        wb_data,
  output logic                   csr_we,
  output logic [CSR_AW-1:0]      csr_addr,
  output logic [XLEN-1:0]        csr_wdata,
  output logic                   trap_valid,
  output logic [XLEN-1:0]        trap_pc,
  output logic [XLEN-1:0]        trap_cause,
  output logic [2:0]             xret_valid,
  output logic                   flush,
  output logic [$clog2(DEPTH):0] count
`ifdef COMMIT_PERF_CNT_EN
  ,
  output logic [63:0]            instret,
  output logic [31:0]            trap_cnt
`endif
);

  state_t        state_reg;
  state_t        state_next;
  commit_entry_t wr_entry;
  commit_entry_t head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          retire_trap;
  logic          retire_xret;
  logic          retire_flush;

  assign wr_entry = '{result: in_result, rd: in_rd, we: in_we, pc: in_pc,
                      csr_wb: in_csr_wb, csr_addr: in_csr_addr, csr_we: in_csr_we,
                      cause: in_cause, exc: in_exc, xret: in_xret};

  commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .clear    (retire_flush),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  // DRAIN blocks both ends of the queue until the front-end takes the new PC
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    pop        = 1'b0;
    case (state_reg)
      RUN: begin
        in_ready = !fifo_full;
        pop      = !fifo_empty && !commit_stall;
        if (pop && (head.exc || head.xret != 3'b000)) state_next = DRAIN;
      end
      DRAIN: begin
        if (redirect_ack) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign push         = in_valid && in_ready;
  assign retire_trap  = pop && head.exc;
  assign retire_xret  = pop && !head.exc && (head.xret != 3'b000);
  assign retire_flush = retire_trap || retire_xret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      csr_we     <= 1'b0;
      csr_addr   <= '0;
      csr_wdata  <= '0;
      trap_valid <= 1'b0;
      trap_pc    <= '0;
      trap_cause <= '0;
      xret_valid <= 3'b000;
      flush      <= 1'b0;
    end else begin
      // A trapping entry writes nothing; an xRET may still carry its CSR write
      wb_we      <= pop && !head.exc && (head.xret == 3'b000) && head.we && (head.rd != 5'd0);
      csr_we     <= pop && !head.exc && head.csr_we;
      trap_valid <= retire_trap;
      xret_valid <= retire_xret ? head.xret : 3'b000;
      flush      <= retire_flush;
      if (pop) begin
        wb_rd      <= head.rd;
        wb_data    <= head.result;
        csr_addr   <= head.csr_addr;
        csr_wdata  <= head.csr_wb;
        trap_pc    <= head.pc;
        trap_cause <= head.cause;
      end
    end
  end

`ifdef COMMIT_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret  <= '0;
      trap_cnt <= '0;
    end else begin
      if (pop && !head.exc) instret <= instret + 64'd1;
      if (retire_trap)      trap_cnt <= trap_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_commit_queue.sv
// Bench for commit_queue: directed vector table, reset-in-DRAIN sequence, then random traffic against a queue model.
module tb_commit_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] pc;
    logic [31:0] cdata;
    logic [11:0] caddr;
    logic        cwe;
    logic [31:0] cause;
    logic        exc;
    logic [2:0]  xret;
  } ent_t;

  typedef struct {
    bit          v;
    ent_t        e;
    bit          stall;
    bit          ack;
    bit          e_we;
    logic [31:0] e_data;   // wb_data, trap_pc or csr_addr, whichever strobe is expected
    bit          e_trap;
    bit          e_flush;
    logic [2:0]  e_xret;
    bit          e_cwe;
    int          e_cnt;
    bit          e_rdy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_result, in_pc, in_csr_wb, in_cause;
  logic [4:0]  in_rd;
  logic        in_we, in_csr_we, in_exc;
  logic [11:0] in_csr_addr;
  logic [2:0]  in_xret;
  logic        commit_stall, redirect_ack;
  logic        wb_we, csr_we, trap_valid, flush;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, csr_wdata, trap_pc, trap_cause;
  logic [11:0] csr_addr;
  logic [2:0]  xret_valid;
  logic [2:0]  count;
`ifdef COMMIT_PERF_CNT_EN
  logic [63:0] instret;
  logic [31:0] trap_cnt;
  longint unsigned m_instret;
  int unsigned     m_trap_cnt;
`endif

  int   n_cmp = 0;
  int   n_fail = 0;
  ent_t mq[$];
  bit   m_drain;
  ent_t cur_e;
  vec_t tbl[$];

  commit_queue #(.XLEN(32), .DEPTH(DEPTH), .CSR_AW(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_rd(in_rd), .in_we(in_we), .in_pc(in_pc),
    .in_csr_wb(in_csr_wb), .in_csr_addr(in_csr_addr), .in_csr_we(in_csr_we),
    .in_cause(in_cause), .in_exc(in_exc), .in_xret(in_xret),
    .commit_stall(commit_stall), .redirect_ack(redirect_ack),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .csr_we(csr_we),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .trap_valid(trap_valid),
    .trap_pc(trap_pc), .trap_cause(trap_cause), .xret_valid(xret_valid),
    .flush(flush), .count(count)
`ifdef COMMIT_PERF_CNT_EN
    , .instret(instret), .trap_cnt(trap_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic ent_t mk(logic [4:0] rd, bit we, logic [31:0] res, logic [31:0] pc, bit exc,
                              logic [31:0] cause, logic [2:0] xret, bit cwe, logic [11:0] caddr);
    ent_t e;
    e.rd = rd; e.we = we; e.res = res; e.pc = pc; e.exc = exc; e.cause = cause;
    e.xret = xret; e.cwe = cwe; e.caddr = caddr; e.cdata = ~res;
    return e;
  endfunction

  function automatic vec_t r(bit v, ent_t e, bit stall, bit ack, bit e_we, logic [31:0] e_data,
                             bit e_trap, bit e_flush, logic [2:0] e_xret, bit e_cwe, int e_cnt, bit e_rdy);
    vec_t t;
    t.v = v; t.e = e; t.stall = stall; t.ack = ack; t.e_we = e_we; t.e_data = e_data;
    t.e_trap = e_trap; t.e_flush = e_flush; t.e_xret = e_xret; t.e_cwe = e_cwe;
    t.e_cnt = e_cnt; t.e_rdy = e_rdy;
    return t;
  endfunction

  task automatic apply(bit v, ent_t e, bit stall, bit ack);
    cur_e = e;
    in_valid = v; in_result = e.res; in_rd = e.rd; in_we = e.we; in_pc = e.pc;
    in_csr_wb = e.cdata; in_csr_addr = e.caddr; in_csr_we = e.cwe; in_cause = e.cause;
    in_exc = e.exc; in_xret = e.xret; commit_stall = stall; redirect_ack = ack;
  endtask

  task automatic model_reset();
    mq.delete();
    m_drain = 1'b0;
`ifdef COMMIT_PERF_CNT_EN
    m_instret = 0;
    m_trap_cnt = 0;
`endif
  endtask

  // Reference: an in-order queue retiring at most one entry per cycle; trap/xRET empties it
  task automatic cycle(string tag);
    ent_t h;
    bit rdy, pop, x_we, x_cwe, x_trap, x_fl;
    logic [2:0] x_xret;
    x_we = 0; x_cwe = 0; x_trap = 0; x_fl = 0; x_xret = 3'b000;
    rdy = !m_drain && (mq.size() < DEPTH);
    pop = !m_drain && (mq.size() > 0) && !commit_stall;
    if (pop) begin
      h = mq.pop_front();
      if (h.exc) begin
        x_trap = 1; x_fl = 1;
`ifdef COMMIT_PERF_CNT_EN
        m_trap_cnt++;
`endif
      end else begin
        x_xret = h.xret;
        x_fl   = (h.xret != 3'b000);
        x_we   = h.we && (h.rd != 5'd0) && !x_fl;
        x_cwe  = h.cwe;
`ifdef COMMIT_PERF_CNT_EN
        m_instret++;
`endif
      end
    end
    if (x_fl) mq.delete();
    else if (in_valid && rdy) mq.push_back(cur_e);
    if (m_drain) m_drain = !redirect_ack;
    else m_drain = x_fl;
    @(posedge clk); #1;
    chk({tag, ".wb_we"}, wb_we, x_we);
    chk({tag, ".csr_we"}, csr_we, x_cwe);
    chk({tag, ".trap_valid"}, trap_valid, x_trap);
    chk({tag, ".xret_valid"}, xret_valid, x_xret);
    chk({tag, ".flush"}, flush, x_fl);
    chk({tag, ".count"}, count, mq.size());
    chk({tag, ".in_ready"}, in_ready, !m_drain && (mq.size() < DEPTH));
    if (x_we) begin
      chk({tag, ".wb_rd"}, wb_rd, h.rd);
      chk({tag, ".wb_data"}, wb_data, h.res);
    end
    if (x_cwe) begin
      chk({tag, ".csr_addr"}, csr_addr, h.caddr);
      chk({tag, ".csr_wdata"}, csr_wdata, h.cdata);
    end
    if (x_trap) begin
      chk({tag, ".trap_pc"}, trap_pc, h.pc);
      chk({tag, ".trap_cause"}, trap_cause, h.cause);
    end
`ifdef COMMIT_PERF_CNT_EN
    chk({tag, ".instret"}, instret, m_instret);
    chk({tag, ".trap_cnt"}, trap_cnt, m_trap_cnt);
`endif
  endtask

  task automatic check_reset(string tag);
    chk({tag, ".wb_we"}, wb_we, 0);
    chk({tag, ".wb_rd"}, wb_rd, 0);
    chk({tag, ".wb_data"}, wb_data, 0);
    chk({tag, ".csr_we"}, csr_we, 0);
    chk({tag, ".csr_addr"}, csr_addr, 0);
    chk({tag, ".csr_wdata"}, csr_wdata, 0);
    chk({tag, ".trap_valid"}, trap_valid, 0);
    chk({tag, ".trap_pc"}, trap_pc, 0);
    chk({tag, ".trap_cause"}, trap_cause, 0);
    chk({tag, ".xret_valid"}, xret_valid, 0);
    chk({tag, ".flush"}, flush, 0);
    chk({tag, ".count"}, count, 0);
    chk({tag, ".in_ready"}, in_ready, 1);
`ifdef COMMIT_PERF_CNT_EN
    chk({tag, ".instret"}, instret, 0);
    chk({tag, ".trap_cnt"}, trap_cnt, 0);
`endif
  endtask

  initial begin
    ent_t z, e;
    int unsigned k;
    logic [2:0] xr;
    string tag;

    z = mk(5'd0, 0, 32'h0, 32'h0, 0, 32'h0, 3'b000, 0, 12'h0);
    rst = 1'b1;
    apply(0, z, 0, 0);
    model_reset();
    #1;
    check_reset("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // v, entry, stall, ack | wb_we, data, trap, flush, xret, csr_we, count, in_ready
    tbl.push_back(r(1, mk(5'd5, 1, 32'hDEADBEEF, 32'h1000, 0, 0, 3'b000, 0, 12'h0), 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1));
    tbl.push_back(r(0, z, 0, 0, 1, 32'hDEADBEEF, 0, 0, 3'b000, 0, 0, 1));
    tbl.push_back(r(0, z, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1));
    tbl.push_back(r(1, mk(5'd1, 1, 32'h11, 32'h1004, 0, 0, 3'b000, 0, 12'h0), 1, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1));
    tbl.push_back(r(1, mk(5'd2, 1, 32'h22, 32'h1008, 0, 0, 3'b000, 0, 12'h0), 1, 0, 0, 0, 0, 0, 3'b000, 0, 2, 1));
    tbl.push_back(r(1, mk(5'd3, 1, 32'h33, 32'h100C, 0, 0, 3'b000, 0, 12'h0), 1, 0, 0, 0, 0, 0, 3'b000, 0, 3, 1));
    tbl.push_back(r(1, mk(5'd4, 1, 32'h44, 32'h1010, 0, 0, 3'b000, 0, 12'h0), 1, 0, 0, 0, 0, 0, 3'b000, 0, 4, 0));
    tbl.push_back(r(1, mk(5'd9, 1, 32'h99, 32'h1014, 0, 0, 3'b000, 0, 12'h0), 1, 0, 0, 0, 0, 0, 3'b000, 0, 4, 0));
    tbl.push_back(r(0, z, 0, 0, 1, 32'h11, 0, 0, 3'b000, 0, 3, 1));
    tbl.push_back(r(0, z, 0, 0, 1, 32'h22, 0, 0, 3'b000, 0, 2, 1));
    tbl.push_back(r(0, z, 0, 0, 1, 32'h33, 0, 0, 3'b000, 0, 1, 1));
    tbl.push_back(r(0, z, 0, 0, 1, 32'h44, 0, 0, 3'b000, 0, 0, 1));
    tbl.push_back(r(0, z, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1));
    tbl.push_back(r(1, mk(5'd6, 1, 32'hA, 32'h0FC, 0, 0, 3'b000, 0, 12'h0), 1, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1));
    tbl.push_back(r(1, mk(5'd7, 1, 32'hB, 32'h100, 1, 32'd2, 3'b000, 0, 12'h0), 1, 0, 0, 0, 0, 0, 3'b000, 0, 2, 1));
    tbl.push_back(r(1, mk(5'd8, 1, 32'hC, 32'h104, 0, 0, 3'b000, 0, 12'h0), 1, 0, 0, 0, 0, 0, 3'b000, 0, 3, 1));
    tbl.push_back(r(1, mk(5'd9, 1, 32'hD, 32'h108, 0, 0, 3'b000, 0, 12'h0), 1, 0, 0, 0, 0, 0, 3'b000, 0, 4, 0));
    tbl.push_back(r(0, z, 0, 0, 1, 32'hA, 0, 0, 3'b000, 0, 3, 1));
    tbl.push_back(r(0, z, 0, 0, 0, 32'h100, 1, 1, 3'b000, 0, 0, 0));
    tbl.push_back(r(0, z, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0));
    tbl.push_back(r(1, mk(5'd10, 1, 32'hE, 32'h10C, 0, 0, 3'b000, 0, 12'h0), 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0));
    tbl.push_back(r(0, z, 0, 1, 0, 0, 0, 0, 3'b000, 0, 0, 1));
    tbl.push_back(r(1, mk(5'd11, 1, 32'h1234, 32'h200, 0, 0, 3'b100, 1, 12'h300), 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1));
    tbl.push_back(r(1, mk(5'd12, 1, 32'h5678, 32'h204, 0, 0, 3'b000, 0, 12'h0), 0, 0, 0, 32'h300, 0, 1, 3'b100, 1, 0, 0));
    tbl.push_back(r(0, z, 0, 1, 0, 0, 0, 0, 3'b000, 0, 0, 1));
    tbl.push_back(r(0, z, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1));
    tbl.push_back(r(1, mk(5'd0, 1, 32'h55, 32'h300, 0, 0, 3'b000, 0, 12'h0), 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1));
    tbl.push_back(r(0, z, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1));
    tbl.push_back(r(1, mk(5'd3, 1, 32'h66, 32'h304, 0, 0, 3'b010, 0, 12'h0), 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1));
    tbl.push_back(r(0, z, 0, 0, 0, 0, 0, 1, 3'b010, 0, 0, 0));
    tbl.push_back(r(0, z, 0, 1, 0, 0, 0, 0, 3'b000, 0, 0, 1));

    foreach (tbl[i]) begin
      tag = $sformatf("t%0d", i);
      apply(tbl[i].v, tbl[i].e, tbl[i].stall, tbl[i].ack);
      cycle(tag);
      chk({tag, ".tbl_count"}, count, tbl[i].e_cnt);
      chk({tag, ".tbl_ready"}, in_ready, tbl[i].e_rdy);
      chk({tag, ".tbl_wb_we"}, wb_we, tbl[i].e_we);
      chk({tag, ".tbl_trap"}, trap_valid, tbl[i].e_trap);
      chk({tag, ".tbl_flush"}, flush, tbl[i].e_flush);
      chk({tag, ".tbl_xret"}, xret_valid, tbl[i].e_xret);
      chk({tag, ".tbl_csr_we"}, csr_we, tbl[i].e_cwe);
      if (tbl[i].e_we)   chk({tag, ".tbl_wb_data"}, wb_data, tbl[i].e_data);
      if (tbl[i].e_trap) chk({tag, ".tbl_trap_pc"}, trap_pc, tbl[i].e_data);
      if (tbl[i].e_cwe)  chk({tag, ".tbl_csr_addr"}, csr_addr, tbl[i].e_data);
    end
`ifdef COMMIT_PERF_CNT_EN
    chk("perf.instret", instret, 64'd9);
    chk("perf.trap_cnt", trap_cnt, 32'd1);
`endif

    // Reset asserted while waiting in DRAIN
    apply(1, mk(5'd4, 1, 32'h77, 32'h200, 1, 32'd5, 3'b000, 0, 12'h0), 0, 0);
    cycle("rdr0");
    apply(0, z, 0, 0);
    cycle("rdr1");
    chk("rdr.drain_ready", in_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    check_reset("rst_drain");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cycle("post_rst");

    for (int i = 0; i < 1500; i++) begin
      k  = $urandom_range(0, 15);
      xr = 3'b000;
      if (k <= 1) xr = 3'b001 << $urandom_range(0, 2);
      e = mk(5'($urandom), 1'($urandom), $urandom, $urandom, k == 0, 32'($urandom_range(0, 15)),
             xr, 1'($urandom), 12'($urandom));
      apply($urandom_range(0, 9) < 6, e, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_queue.md
Name: commit_queue

Overview:
- Parametrised successor to the single-entry commit stage. Buffers up to DEPTH completed instructions from stage 6 and retires them in order, at most one per cycle.
- Drives the register-file and CSR write ports, and raises precise trap/xRET pulses toward the CSR/front-end. Younger queued entries are flushed on any trap or xRET.
- A redirect handshake holds the queue until the front-end acknowledges the new PC.

Parameters:
XLEN, 32, data/PC/cause width
DEPTH, 4, queue entries; power of two, >=2
CSR_AW, 12, CSR address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  stage-6 entry valid
in_ready  out  1  queue can accept
in_result  in  XLEN  GPR writeback data
in_rd  in  5  destination register
in_we  in  1  GPR write enable
in_pc  in  XLEN  instruction PC
in_csr_wb  in  XLEN  CSR write data
in_csr_addr  in  CSR_AW  CSR address
in_csr_we  in  1  CSR write enable
in_cause  in  XLEN  trap cause
in_exc  in  1  exception pending
in_xret  in  3  {mret,sret,uret}, one-hot or zero
commit_stall  in  1  hold retirement this cycle
redirect_ack  in  1  front-end accepted trap/xRET redirect
wb_we  out  1  GPR write strobe
wb_rd  out  5  GPR index
wb_data  out  XLEN  GPR data
csr_we  out  1  CSR write strobe
csr_addr  out  CSR_AW  CSR address
csr_wdata  out  XLEN  CSR data
trap_valid  out  1  exception retired (pulse)
trap_pc  out  XLEN  PC of trapping instruction
trap_cause  out  XLEN  cause
xret_valid  out  3  {mret,sret,uret} retired (pulse)
flush  out  1  younger pipeline state invalid (pulse)
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst=1): all outputs 0, count=0, pointers 0, state RUN. Reset asserted mid-DRAIN also returns to RUN with the queue empty.
- Circular buffer, wr_ptr/rd_ptr of $clog2(DEPTH) bits with natural wrap.
- in_ready = (state==RUN) && (count<DEPTH). Push on in_valid&&in_ready.
- Pop condition: state==RUN, count>0, commit_stall=0.
- Outputs are registered from the head entry at the pop edge, so an entry pushed into an empty queue at edge E0 is retired and visible at edge E1. Latency is 1 cycle.
- Normal pop: wb_we=in_we&&rd!=0; csr_we=csr_we. Both strobes last 1 cycle.
- Trap pop (exc=1): wb_we=0, csr_we=0; trap_valid=1, trap_pc, trap_cause, flush=1 for 1 cycle. Go to DRAIN.
- xRET pop (exc=0, xret!=0): wb_we=0; csr_we follows the entry; xret_valid=entry xret, flush=1 for 1 cycle. Go to DRAIN.
- Flush edge: count:=0 and rd_ptr:=wr_ptr. A push on the same edge is discarded; flush wins.
- State machine:
  - RUN -> DRAIN on trap/xRET pop.
  - DRAIN: in_ready=0, no pops, strobes 0. DRAIN -> RUN on redirect_ack.
  - redirect_ack while in RUN is ignored.
- Simultaneous push and pop: count unchanged. Full with a pop: in_ready stays 0 that cycle (no same-cycle slot reuse).
- commit_stall=1: no pop; all strobes are 0 that cycle; data outputs hold.
- Empty: strobes 0.

Optional Feature:
- Macro COMMIT_PERF_CNT_EN.
- Defined:
  - Adds outputs instret (64-bit) and trap_cnt (32-bit), reset to 0.
  - instret increments on every normal or xRET pop. Trap pops do not count.
  - trap_cnt increments on trap pops. Both wrap.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package commit_pkg: the commit_entry_t struct (result, rd, we, pc, csr_wb, csr_addr, csr_we, cause, exc, xret), the state enum {RUN, DRAIN}, and XRET_M/S/U bit indices.
- One sub-module, commit_fifo: storage plus pointers and count, with push/pop/clear. The retire/trap FSM lives in the top module.

Test Plan:
- Single entry, rd=5, we=1, result=0xDEADBEEF pushed to an empty queue -> one cycle later wb_we=1, wb_rd=5, wb_data=0xDEADBEEF for exactly 1 cycle; count returns to 0.
- Hold commit_stall=1 and push 4 entries -> count=4, in_ready=0. Release the stall -> 4 consecutive in-order writebacks, one per cycle.
- Queue holds A (normal), B (exc, cause=2, pc=0x100), C, D -> A writes back; then trap_valid=1, trap_pc=0x100, trap_cause=2, flush=1, wb_we=0; C and D never retire; count=0; in_ready=0 until redirect_ack.
- mret entry with csr_we=1, addr=0x300 -> csr_we=1, xret_valid=3'b100, flush=1; an in_valid on the same edge is dropped; RUN resumes after redirect_ack.
- Entry with rd=0, we=1 -> wb_we=0. Assert rst while in DRAIN -> all outputs 0, state RUN, in_ready=1.
- With COMMIT_PERF_CNT_EN: 3 normal pops, 1 trap, 1 sret -> instret=4, trap_cnt=1.
